instruction_memory_responder: RTL
=================================

// Module: instruction_memory_responder
// PURPOSE
//  Memory-side responder for the Fetch step's instruction request handshake. Holds the program image.
//  Accepts a level request (get_instruction_i + mem_address_i) and returns the addressed 32-bit word
//  after a programmable latency. Raises instruction_completed_i (seen by Fetch) as a level until the
//  request drops. Sits between the core top level and FetchStep; also offers a preload port for benches.
// PARAMETERS
//  BASE_ADDR  32'h8000_0000  byte address of word 0; matches the Fetch reset PC
//  MEM_WORDS  1024           depth in 32-bit words; power of two
//  LATENCY    2              cycles from request accept to data valid; legal range 1..15
//  NOP_WORD   32'h0000_0013  word returned on out-of-range or misaligned access (addi x0,x0,0)
// PORTS
//  clk_i                    in   1   clock, rising edge
//  rst_i                    in   1   synchronous, active-high reset
//  get_instruction_i        in   1   fetch request level, held until completion is observed
//  mem_address_i            in   32  byte address of the requested instruction
//  instruction_o            out  32  returned instruction word; stable while instruction_completed_o=1
//  instruction_completed_o  out  1   response valid level
//  access_fault_o           out  1   response flag, valid with instruction_completed_o: address fault
//  load_en_i                in   1   preload write strobe
//  load_addr_i              in   32  preload byte address; same mapping as fetch
//  load_data_i              in   32  preload data
// BEHAVIOUR
//  Reset (rst_i=1 at posedge): state=IDLE; instruction_o=0; instruction_completed_o=0;
//   access_fault_o=0; latency counter=0. Memory contents are not cleared.
//   A reset mid-transaction aborts the transaction and returns no response.
//  Address map: idx = (addr - BASE_ADDR) >> 2, computed in 32 bits with wrap.
//   In range iff addr >= BASE_ADDR and idx < MEM_WORDS. Misaligned iff addr[1:0] != 0.
//  FSM states:
//   IDLE: on get_instruction_i=1, latch mem_address_i and load the counter with LATENCY-1,
//    then go to BUSY. Otherwise stay in IDLE.
//   BUSY: decrement the counter each cycle. When the counter is 0, read the array and go to RESP.
//    instruction_o is driven with the array word, or NOP_WORD on a fault.
//    access_fault_o is 1 for out-of-range or misaligned addresses.
//   RESP: instruction_completed_o=1, and instruction_o / access_fault_o are held.
//    Go to IDLE on the cycle get_instruction_i samples 0.
//    completed drops the cycle after that sample; instruction_o keeps its last value.
//  Latency: a request sampled at edge N gives completed=1 after edge N+LATENCY.
//   Consumers may sample on any later cycle, since the response is a level, not a pulse.
//  A request dropped while in BUSY is not cancelled: the FSM completes, enters RESP, and
//   exits on the next edge where the request is sampled low.
//  mem_address_i changes after acceptance are ignored; the latched address is used.
//  Back-to-back: request re-raised one cycle after drop is accepted from IDLE.
//   Minimum period = LATENCY+2 cycles.
//  Preload: load_en_i writes the array at the next edge in any state.
//   Out-of-range or misaligned writes are dropped silently.
//   A write to the same word on the read edge returns the old data (read-before-write).
//  rst_i has priority over load_en_i; no write occurs during reset.
// STRUCTURE
//  Shared definitions.vh: RESP_IDLE/RESP_BUSY/RESP_RESP state codes (2 bits), NOP encoding,
//   RESET_PC = 32'h8000_0000 (also used by Fetch).
//  Sub-module instr_mem_array: MEM_WORDS x 32 array with a synchronous read port (re, ridx, rdata)
//   and one write port (we, widx, wdata); read-before-write.
//  Top holds the FSM, counter, address decode and fault logic.
// TESTING
//  1 Reset: rst_i=1 for 2 cycles with get=1 -> completed=0, instruction_o=0, fault=0.
//  2 Basic: preload 0x8000_0000=0x0050_0093; LATENCY=2; raise get at edge 0
//    -> completed=1 after edge 2, instruction_o=0x0050_0093; drop get -> completed=0 next cycle.
//  3 Slow consumer: hold get for 10 cycles after completion -> completed and data stable throughout.
//    Sampling on alternate cycles (Fetch STALL pattern) still sees the word.
//  4 Faults: addr 0x8000_0002 -> NOP 0x0000_0013, fault=1.
//    addr 0x7FFF_FFFC and BASE+4*MEM_WORDS -> NOP, fault=1.
//  5 Sequential fetch: request PC 0x8000_0000,+4,+8 with a 1-cycle gap
//    -> three words returned in order, each completing LATENCY cycles after acceptance.
//  6 Mid-op reset / collisions: assert rst_i in BUSY -> no completion, back to IDLE.
//    A preload to the same word on the read edge returns the old value; the new value is seen next fetch.

Source files
------------

// File: rtl/instruction_memory_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_memory_responder_pkg
// Description : Shared definitions for the instruction memory responder.
//               It defines the responder state codes, the NOP encoding, the
//               Fetch reset PC, and the address-decode helpers that the fetch
//               port and the preload port both use.
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_memory_responder_pkg;

    // Responder FSM state codes
    localparam logic [1:0] RESP_IDLE = 2'd0;
    localparam logic [1:0] RESP_BUSY = 2'd1;
    localparam logic [1:0] RESP_RESP = 2'd2;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_ENCODING = 32'h0000_0013;

    // Fetch reset PC. This is also the default base of the program image.
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    // Word index relative to the image base. The subtraction wraps in 32 bits,
    // so an address below the base yields a large index.
    function automatic logic [31:0] word_index(input logic [31:0] addr,
                                               input logic [31:0] base);
        return (addr - base) >> 2;
    endfunction

    // True when the address falls inside the image.
    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] idx,
                                      input logic [31:0] words);
        return (addr >= base) && (idx < words);
    endfunction

endpackage : instruction_memory_responder_pkg
`default_nettype wire

// File: rtl/instruction_memory_responder_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : instruction_memory_responder_mem_array
// Description : Instruction memory array with MEM_WORDS x 32-bit words.
//               It has one synchronous read port and one write port.
//               When both ports address the same word on one edge, the read
//               returns the old data (read-before-write). The read data
//               register holds its value while re is low.
// Ports       : clk   - clock, rising edge
//               re    - read enable
//               ridx  - read word index
//               rdata - registered read data
//               we    - write enable
//               widx  - write word index
//               wdata - write data
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_memory_responder_mem_array #(
    parameter int MEM_WORDS = 1024,
    parameter int IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic             clk,
    input  logic             re,
    input  logic [IDX_W-1:0] ridx,
    output logic [31:0]      rdata,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [31:0]      wdata
);

    logic [31:0] r_mem [MEM_WORDS];
    logic [31:0] r_rdata;

    // Non-blocking assignments give read-before-write on a same-word collision.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[widx] <= wdata;
        end
        if (re) begin
            r_rdata <= r_mem[ridx];
        end
    end

    assign rdata = r_rdata;

endmodule : instruction_memory_responder_mem_array
`default_nettype wire

// File: rtl/instruction_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : instruction_memory_responder
// Description : Memory-side responder for the Fetch instruction handshake.
//               It accepts a level request, waits LATENCY cycles, and then
//               returns the addressed word (NOP plus a fault flag for a bad
//               address). The response stays up as a level until the
//               request drops. A preload port writes the program image.
// Ports       : clk_i                   - clock, rising edge
//               rst_i                   - synchronous active-high reset
//               get_instruction_i       - fetch request level
//               mem_address_i           - requested byte address
//               instruction_o           - returned instruction word
//               instruction_completed_o - response valid level
//               access_fault_o          - address fault, valid with completed
//               load_en_i               - preload write strobe
//               load_addr_i             - preload byte address
//               load_data_i             - preload data
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_memory_responder
    import instruction_memory_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = RESET_PC,
    parameter int          MEM_WORDS = 1024,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] NOP_WORD  = NOP_ENCODING
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        get_instruction_i,
    input  logic [31:0] mem_address_i,
    output logic [31:0] instruction_o,
    output logic        instruction_completed_o,
    output logic        access_fault_o,
    input  logic        load_en_i,
    input  logic [31:0] load_addr_i,
    input  logic [31:0] load_data_i
);

    localparam int          IDX_W      = $clog2(MEM_WORDS);
    localparam logic [3:0]  c_lat_init = 4'(LATENCY - 1);
    localparam logic [31:0] c_words    = 32'(MEM_WORDS);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [3:0]       r_count;
    logic [31:0]      r_addr;
    logic             r_fault;
    logic             r_has_data;

    logic [31:0]      w_rd_idx;
    logic             w_rd_fault;
    logic             w_re;
    logic [31:0]      w_rdata;

    logic [31:0]      w_ld_idx;
    logic             w_we;

    // ------------------------------------------------------------------
    // Address decode. The fetch side decodes the latched address. The
    // preload side decodes the live load address.
    // ------------------------------------------------------------------
    assign w_rd_idx   = word_index(r_addr, BASE_ADDR);
    assign w_rd_fault = !in_range(r_addr, BASE_ADDR, w_rd_idx, c_words)
                        || (r_addr[1:0] != 2'b00);

    assign w_ld_idx   = word_index(load_addr_i, BASE_ADDR);
    // Reset blocks writes, and bad preload addresses are dropped silently.
    assign w_we       = load_en_i && !rst_i
                        && in_range(load_addr_i, BASE_ADDR, w_ld_idx, c_words)
                        && (load_addr_i[1:0] == 2'b00);

    instruction_memory_responder_mem_array #(
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (IDX_W)
    ) u_mem_array (
        .clk   (clk_i),
        .re    (w_re),
        .ridx  (w_rd_idx[IDX_W-1:0]),
        .rdata (w_rdata),
        .we    (w_we),
        .widx  (w_ld_idx[IDX_W-1:0]),
        .wdata (load_data_i)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= RESP_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RESP_IDLE: if (get_instruction_i) w_next_state = RESP_BUSY;
            // A request dropped during BUSY does not cancel the transaction.
            RESP_BUSY: if (r_count == 4'd0)   w_next_state = RESP_RESP;
            RESP_RESP: if (!get_instruction_i) w_next_state = RESP_IDLE;
            default:   w_next_state = RESP_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        instruction_completed_o = (r_state == RESP_RESP);
        // The array is read only for a good address. A faulting access
        // leaves the read register untouched and drives NOP instead.
        w_re = (r_state == RESP_BUSY) && (r_count == 4'd0) && !w_rd_fault;
        if (!r_has_data) begin
            instruction_o = 32'd0;
        end else if (r_fault) begin
            instruction_o = NOP_WORD;
        end else begin
            instruction_o = w_rdata;
        end
        access_fault_o = r_fault;
    end

    // ------------------------------------------------------------------
    // Datapath: latched address, latency counter, and response flags.
    // r_has_data forces instruction_o to zero from reset until the first
    // read completes. The array itself is not reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count    <= 4'd0;
            r_addr     <= 32'd0;
            r_fault    <= 1'b0;
            r_has_data <= 1'b0;
        end else begin
            case (r_state)
                RESP_IDLE: begin
                    if (get_instruction_i) begin
                        r_addr  <= mem_address_i;
                        r_count <= c_lat_init;
                    end
                end
                RESP_BUSY: begin
                    if (r_count != 4'd0) begin
                        r_count <= r_count - 4'd1;
                    end else begin
                        r_fault    <= w_rd_fault;
                        r_has_data <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule : instruction_memory_responder
`default_nettype wire
